// File: rtl/vgachargen_pkg.sv
// vgachargen_pkg: types and constants shared by the text console
// front end and the character generator core.
package vgachargen_pkg;

  localparam int DEF_COLS = 80;
  localparam int DEF_ROWS = 60;

  localparam logic [7:0] CC_BS = 8'h08;
  localparam logic [7:0] CC_LF = 8'h0A;
  localparam logic [7:0] CC_FF = 8'h0C;
  localparam logic [7:0] CC_CR = 8'h0D;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLR_LINE,
    ST_CLR_SCREEN
  } console_state_e;

endpackage

// File: rtl/vgachargen_cursor.sv
// vgachargen_cursor: row/col cursor with an incrementally kept line
// base, so the linear address never needs a multiplier.
module vgachargen_cursor
  import vgachargen_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS,
  parameter int CW   = $clog2(COLS),
  parameter int RW   = $clog2(ROWS),
  parameter int AW   = $clog2(COLS*ROWS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          col_inc_i,
  input  logic          col_dec_i,
  input  logic          col_zero_i,
  input  logic          row_adv_i,
  input  logic          home_i,
  output logic [RW-1:0] row_o,
  output logic [CW-1:0] col_o,
  output logic [AW-1:0] addr_o
);

  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [AW-1:0] base_q, base_d;

  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    base_d = base_q;
    if (home_i) begin
      row_d  = '0;
      col_d  = '0;
      base_d = '0;
    end else begin
      if (col_zero_i) begin
        col_d = '0;
      end else if (col_inc_i) begin
        col_d = col_q + CW'(1);
      end else if (col_dec_i) begin
        col_d = col_q - CW'(1);
      end
      // base tracks row*COLS; wrap resets it rather than subtracting
      if (row_adv_i) begin
        if (row_q == RW'(ROWS-1)) begin
          row_d  = '0;
          base_d = '0;
        end else begin
          row_d  = row_q + RW'(1);
          base_d = base_q + AW'(COLS);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      row_q  <= '0;
      col_q  <= '0;
      base_q <= '0;
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      base_q <= base_d;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign addr_o = base_q + AW'(col_q);

endmodule

// File: rtl/vgachargen_console.sv
// vgachargen_console: byte-stream terminal front end driving text writes.
// Line clear on row advance enabled by VGACHARGEN_CONSOLE_LINE_CLEAR_EN.
module vgachargen_console
  import vgachargen_pkg::*;
#(
  parameter int         COLS       = DEF_COLS,
  parameter int         ROWS       = DEF_ROWS,
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [7:0]                    data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic [7:0]                    char_o,
  output logic [$clog2(COLS*ROWS)-1:0]  addr_o,
  output logic                          wen_o,
  output logic [$clog2(ROWS)-1:0]       cur_row_o,
  output logic [$clog2(COLS)-1:0]       cur_col_o,
  output logic                          busy_o
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int AW = $clog2(COLS*ROWS);

  localparam logic [AW-1:0] LAST_COL  = AW'(COLS-1);
  localparam logic [AW-1:0] LAST_CELL = AW'(COLS*ROWS-1);

  console_state_e state_q, state_d;
  logic [AW-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [7:0]     char_q, char_d;
  logic           wen_q, wen_d;

  logic          col_inc, col_dec, col_zero, row_adv, home;
  logic [CW-1:0] cur_col;
  logic [RW-1:0] cur_row;
  logic [AW-1:0] cur_addr;
  logic          accept, printable;

  vgachargen_cursor #(
    .COLS (COLS),
    .ROWS (ROWS),
    .CW   (CW),
    .RW   (RW),
    .AW   (AW)
  ) u_cursor (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .col_inc_i  (col_inc),
    .col_dec_i  (col_dec),
    .col_zero_i (col_zero),
    .row_adv_i  (row_adv),
    .home_i     (home),
    .row_o      (cur_row),
    .col_o      (cur_col),
    .addr_o     (cur_addr)
  );

  assign ready_o   = (state_q == ST_IDLE) && !rst_i;
  assign busy_o    = (state_q != ST_IDLE);
  assign accept    = valid_i && ready_o;
  assign printable = (data_i >= 8'h20) && (data_i <= 8'h7E);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    char_d   = char_q;
    wen_d    = 1'b0;
    col_inc  = 1'b0;
    col_dec  = 1'b0;
    col_zero = 1'b0;
    row_adv  = 1'b0;
    home     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          unique case (1'b1)
            printable: begin
              wen_d  = 1'b1;
              char_d = data_i;
              addr_d = cur_addr;
              if (cur_col == CW'(COLS-1)) begin
                col_zero = 1'b1;
                row_adv  = 1'b1;
              end else begin
                col_inc = 1'b1;
              end
            end
            (data_i == CC_LF): begin
              col_zero = 1'b1;
              row_adv  = 1'b1;
            end
            (data_i == CC_CR): col_zero = 1'b1;
            (data_i == CC_BS): begin
              if (cur_col != '0) begin
                col_dec = 1'b1;
                wen_d   = 1'b1;
                char_d  = BLANK_CHAR;
                addr_d  = cur_addr - AW'(1);
              end
            end
            (data_i == CC_FF): begin
              state_d = ST_CLR_SCREEN;
              cnt_d   = '0;
            end
            default: ;
          endcase
        end
`ifdef VGACHARGEN_CONSOLE_LINE_CLEAR_EN
        if (row_adv) begin
          state_d = ST_CLR_LINE;
          cnt_d   = '0;
        end
`endif
      end
`ifdef VGACHARGEN_CONSOLE_LINE_CLEAR_EN
      // cursor already sits at column 0 of the new row
      ST_CLR_LINE: begin
        wen_d  = 1'b1;
        char_d = BLANK_CHAR;
        addr_d = cur_addr + cnt_q;
        if (cnt_q == LAST_COL) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
`endif
      ST_CLR_SCREEN: begin
        wen_d  = 1'b1;
        char_d = BLANK_CHAR;
        addr_d = cnt_q;
        if (cnt_q == LAST_CELL) begin
          state_d = ST_IDLE;
          home    = 1'b1;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      char_q  <= 8'h00;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      char_q  <= char_d;
      wen_q   <= wen_d;
    end
  end

  assign char_o    = char_q;
  assign addr_o    = addr_q;
  assign wen_o     = wen_q;
  assign cur_row_o = cur_row;
  assign cur_col_o = cur_col;

endmodule

// File: tb/tb_vgachargen_console.sv
// tb_vgachargen_console: randomized and directed bench for the console,
// checked against a cursor/write-list model of the terminal rules.
module tb_vgachargen_console;

  localparam int COLS  = 80;
  localparam int ROWS  = 60;
  localparam int CELLS = COLS * ROWS;
`ifdef VGACHARGEN_CONSOLE_LINE_CLEAR_EN
  localparam bit LINE_CLR = 1'b1;
`else
  localparam bit LINE_CLR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic [7:0]  data_i = 8'h00;
  logic        ready_o, wen_o, busy_o;
  logic [7:0]  char_o;
  logic [12:0] addr_o;
  logic [5:0]  cur_row_o;
  logic [6:0]  cur_col_o;

  always #4 clk = ~clk;

  vgachargen_console dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .data_i    (data_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .char_o    (char_o),
    .addr_o    (addr_o),
    .wen_o     (wen_o),
    .cur_row_o (cur_row_o),
    .cur_col_o (cur_col_o),
    .busy_o    (busy_o)
  );

  typedef struct {
    int cyc;
    int addr;
    int ch;
  } wr_t;

  wr_t got_q[$];
  wr_t exp_q[$];
  int  cyc = 0;
  int  nr_cnt = 0;
  int  busy_cnt = 0;
  int  checks = 0;
  int  errors = 0;
  int  m_row = 0;
  int  m_col = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst_i === 1'b0) begin
      if (wen_o === 1'b1)
        got_q.push_back('{cyc, int'(addr_o), int'(char_o)});
      if (ready_o !== 1'b1) nr_cnt++;
      if (busy_o === 1'b1) busy_cnt++;
    end
  end

  // ---------------- reference model ----------------
  task automatic m_push(int a, int c);
    exp_q.push_back('{0, a, c});
  endtask

  task automatic m_row_adv();
    m_row = (m_row + 1) % ROWS;
    if (LINE_CLR)
      for (int c = 0; c < COLS; c++) m_push(m_row * COLS + c, 32);
  endtask

  task automatic m_apply(logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      m_push(m_row * COLS + m_col, int'(b));
      if (m_col == COLS - 1) begin
        m_col = 0;
        m_row_adv();
      end else begin
        m_col++;
      end
    end else if (b == 8'h0A) begin
      m_col = 0;
      m_row_adv();
    end else if (b == 8'h0D) begin
      m_col = 0;
    end else if (b == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        m_push(m_row * COLS + m_col, 32);
      end
    end else if (b == 8'h0C) begin
      for (int i = 0; i < CELLS; i++) m_push(i, 32);
      m_row = 0;
      m_col = 0;
    end
  endtask

  task automatic clear_obs();
    got_q.delete();
    exp_q.delete();
    nr_cnt   = 0;
    busy_cnt = 0;
  endtask

  // ---------------- drivers ----------------
  task automatic send(logic [7:0] b);
    int n = 0;
    valid_i = 1'b1;
    data_i  = b;
    while (ready_o !== 1'b1 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL send_timeout: ready=%b, required 1", ready_o);
      valid_i = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      m_apply(b);
    end
  endtask

  task automatic drain();
    int n = 0;
    valid_i = 1'b0;
    while (ready_o !== 1'b1 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL drain_timeout: ready=%b, required 1", ready_o);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i   = 1'b1;
    valid_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    m_row = 0;
    m_col = 0;
    clear_obs();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    rst_i   = 1'b1;
    valid_i = 1'b1;
    data_i  = 8'h41;
    repeat (3) @(negedge clk);
    checks++;
    if (wen_o !== 1'b0 || char_o !== 8'h00 || addr_o !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: wen=%b char=%h addr=%0d, required 0 00 0",
               wen_o, char_o, addr_o);
    end
    checks++;
    if (ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: ready=%b, required 0", ready_o);
    end
    checks++;
    if (cur_row_o !== 6'd0 || cur_col_o !== 7'd0) begin
      errors++;
      $display("FAIL reset_cursor: got (%0d,%0d), required (0,0)",
               cur_row_o, cur_col_o);
    end
    valid_i = 1'b0;
    rst_i   = 1'b0;
    #1;
    checks++;
    if (ready_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%b busy=%b, required 1 0",
               ready_o, busy_o);
    end
    @(negedge clk);
    m_row = 0;
    m_col = 0;
    clear_obs();
  endtask

  task automatic test_print_ab();
    do_reset();
    send(8'h41);
    send(8'h42);
    drain();
    checks++;
    if (got_q.size() != 2) begin
      errors++;
      $display("FAIL ab_count: got %0d writes, required 2", got_q.size());
    end
    while (got_q.size() < 2) got_q.push_back('{-1, -1, -1});
    checks++;
    if (got_q[0].addr != 0 || got_q[0].ch != 'h41) begin
      errors++;
      $display("FAIL ab_first: got (%0d,%h), required (0,41)",
               got_q[0].addr, got_q[0].ch);
    end
    checks++;
    if (got_q[1].addr != 1 || got_q[1].ch != 'h42) begin
      errors++;
      $display("FAIL ab_second: got (%0d,%h), required (1,42)",
               got_q[1].addr, got_q[1].ch);
    end
    checks++;
    if (got_q[1].cyc != got_q[0].cyc + 1) begin
      errors++;
      $display("FAIL ab_consecutive: gap %0d cycles, required 1",
               got_q[1].cyc - got_q[0].cyc);
    end
    checks++;
    if (int'(cur_row_o) != m_row || int'(cur_col_o) != m_col) begin
      errors++;
      $display("FAIL ab_cursor: got (%0d,%0d), required (%0d,%0d)",
               cur_row_o, cur_col_o, m_row, m_col);
    end
  endtask

  task automatic test_line_wrap();
    int bad = -1;
    do_reset();
    repeat (COLS) send(8'h78);
    drain();
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (bad < 0 && (got_q[i].addr != exp_q[i].addr ||
                      got_q[i].ch != exp_q[i].ch)) bad = i;
    checks++;
    if (got_q.size() != exp_q.size() || bad >= 0) begin
      errors++;
      $display("FAIL wrap_stream: got %0d writes (bad idx %0d), required %0d",
               got_q.size(), bad, exp_q.size());
    end
    checks++;
    if (nr_cnt != (LINE_CLR ? COLS : 0)) begin
      errors++;
      $display("FAIL wrap_not_ready: got %0d cycles, required %0d",
               nr_cnt, LINE_CLR ? COLS : 0);
    end
    while (got_q.size() < COLS) got_q.push_back('{-1, -1, -1});
    checks++;
    if (got_q[COLS-1].cyc - got_q[0].cyc != COLS - 1) begin
      errors++;
      $display("FAIL wrap_sustained: span %0d cycles, required %0d",
               got_q[COLS-1].cyc - got_q[0].cyc, COLS - 1);
    end
    checks++;
    if (int'(cur_row_o) != m_row || int'(cur_col_o) != m_col) begin
      errors++;
      $display("FAIL wrap_cursor: got (%0d,%0d), required (%0d,%0d)",
               cur_row_o, cur_col_o, m_row, m_col);
    end
  endtask

  task automatic test_lf_wrap();
    int bad = -1;
    int high = 0;
    do_reset();
    repeat (ROWS - 1) send(8'h0A);
    repeat (5) send(8'h61);
    drain();
    checks++;
    if (int'(cur_row_o) != 59 || int'(cur_col_o) != 5) begin
      errors++;
      $display("FAIL lf_setup_cursor: got (%0d,%0d), required (59,5)",
               cur_row_o, cur_col_o);
    end
    clear_obs();
    send(8'h0A);
    drain();
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (bad < 0 && (got_q[i].addr != exp_q[i].addr ||
                      got_q[i].ch != exp_q[i].ch)) bad = i;
    checks++;
    if (got_q.size() != exp_q.size() || bad >= 0) begin
      errors++;
      $display("FAIL lf_stream: got %0d writes (bad idx %0d), required %0d",
               got_q.size(), bad, exp_q.size());
    end
    foreach (got_q[i]) if (got_q[i].addr >= 4720) high++;
    checks++;
    if (high != 0) begin
      errors++;
      $display("FAIL lf_high_writes: got %0d, required 0", high);
    end
    checks++;
    if (int'(cur_row_o) != m_row || int'(cur_col_o) != m_col) begin
      errors++;
      $display("FAIL lf_cursor: got (%0d,%0d), required (%0d,%0d)",
               cur_row_o, cur_col_o, m_row, m_col);
    end
  endtask

  task automatic test_backspace();
    do_reset();
    repeat (3) send(8'h0A);
    drain();
    clear_obs();
    send(8'h08);
    drain();
    checks++;
    if (got_q.size() != exp_q.size() || nr_cnt != 0) begin
      errors++;
      $display("FAIL bs_col0: writes=%0d notready=%0d, required %0d 0",
               got_q.size(), nr_cnt, exp_q.size());
    end
    checks++;
    if (int'(cur_row_o) != m_row || int'(cur_col_o) != m_col) begin
      errors++;
      $display("FAIL bs_col0_cursor: got (%0d,%0d), required (%0d,%0d)",
               cur_row_o, cur_col_o, m_row, m_col);
    end
    repeat (7) send(8'h71);
    drain();
    clear_obs();
    send(8'h08);
    drain();
    checks++;
    if (got_q.size() != 1) begin
      errors++;
      $display("FAIL bs_count: got %0d writes, required 1", got_q.size());
    end
    while (got_q.size() < 1) got_q.push_back('{-1, -1, -1});
    checks++;
    if (got_q[0].addr != exp_q[0].addr || got_q[0].ch != exp_q[0].ch) begin
      errors++;
      $display("FAIL bs_write: got (%0d,%h), required (%0d,%h)",
               got_q[0].addr, got_q[0].ch, exp_q[0].addr, exp_q[0].ch);
    end
    checks++;
    if (int'(cur_row_o) != m_row || int'(cur_col_o) != m_col) begin
      errors++;
      $display("FAIL bs_cursor: got (%0d,%0d), required (%0d,%0d)",
               cur_row_o, cur_col_o, m_row, m_col);
    end
    clear_obs();
    send(8'h7F);
    drain();
    checks++;
    if (got_q.size() != 0 || int'(cur_col_o) != m_col ||
        int'(cur_row_o) != m_row) begin
      errors++;
      $display("FAIL del_discard: writes=%0d cursor (%0d,%0d), required 0 (%0d,%0d)",
               got_q.size(), cur_row_o, cur_col_o, m_row, m_col);
    end
    send(8'h0D);
    drain();
    checks++;
    if (got_q.size() != 0 || int'(cur_col_o) != m_col ||
        int'(cur_row_o) != m_row) begin
      errors++;
      $display("FAIL cr_home_col: writes=%0d cursor (%0d,%0d), required 0 (%0d,%0d)",
               got_q.size(), cur_row_o, cur_col_o, m_row, m_col);
    end
  endtask

  task automatic test_form_feed();
    int bad = -1;
    int n = 0;
    do_reset();
    send(8'h48);
    send(8'h69);
    drain();
    clear_obs();
    send(8'h0C);
    drain();
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (bad < 0 && (got_q[i].addr != exp_q[i].addr ||
                      got_q[i].ch != exp_q[i].ch)) bad = i;
    checks++;
    if (got_q.size() != exp_q.size() || bad >= 0) begin
      errors++;
      $display("FAIL ff_stream: got %0d writes (bad idx %0d), required %0d",
               got_q.size(), bad, exp_q.size());
    end
    checks++;
    if (busy_cnt != CELLS) begin
      errors++;
      $display("FAIL ff_busy: got %0d cycles, required %0d", busy_cnt, CELLS);
    end
    while (got_q.size() < CELLS) got_q.push_back('{-1, -1, -1});
    checks++;
    if (got_q[CELLS-1].cyc - got_q[0].cyc != CELLS - 1) begin
      errors++;
      $display("FAIL ff_consecutive: span %0d, required %0d",
               got_q[CELLS-1].cyc - got_q[0].cyc, CELLS - 1);
    end
    checks++;
    if (int'(cur_row_o) != m_row || int'(cur_col_o) != m_col) begin
      errors++;
      $display("FAIL ff_cursor: got (%0d,%0d), required (%0d,%0d)",
               cur_row_o, cur_col_o, m_row, m_col);
    end
    // abandon a clear part way through
    send(8'h5A);
    send(8'h0C);
    valid_i = 1'b0;
    while (!(wen_o === 1'b1 && addr_o === 13'd99) && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(wen_o === 1'b1 && addr_o === 13'd99)) begin
      errors++;
      $display("FAIL ff_write100: wen=%b addr=%0d, required 1 99",
               wen_o, addr_o);
    end
    rst_i = 1'b1;
    @(negedge clk);
    checks++;
    if (wen_o !== 1'b0 || busy_o !== 1'b0 || ready_o !== 1'b0) begin
      errors++;
      $display("FAIL ff_abort: wen=%b busy=%b ready=%b, required 0 0 0",
               wen_o, busy_o, ready_o);
    end
    checks++;
    if (cur_row_o !== 6'd0 || cur_col_o !== 7'd0) begin
      errors++;
      $display("FAIL ff_abort_cursor: got (%0d,%0d), required (0,0)",
               cur_row_o, cur_col_o);
    end
    rst_i = 1'b0;
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b1 || busy_o !== 1'b0 || wen_o !== 1'b0) begin
      errors++;
      $display("FAIL ff_abort_idle: ready=%b busy=%b wen=%b, required 1 0 0",
               ready_o, busy_o, wen_o);
    end
    m_row = 0;
    m_col = 0;
    clear_obs();
  endtask

  task automatic test_random();
    int bad = -1;
    int ffs = 0;
    logic [7:0] b;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      int sel = $urandom_range(0, 99);
      if (sel < 68) begin
        b = 8'($urandom_range(32, 126));
      end else if (sel < 78) begin
        b = 8'h0A;
      end else if (sel < 84) begin
        b = 8'h0D;
      end else if (sel < 94) begin
        b = 8'h08;
      end else if (sel == 99 && ffs < 2) begin
        b = 8'h0C;
        ffs++;
      end else begin
        do b = 8'($urandom);
        while ((b >= 8'h20 && b <= 8'h7E) || b == 8'h08 ||
               b == 8'h0A || b == 8'h0C || b == 8'h0D);
      end
      send(b);
      if ($urandom_range(0, 7) == 0) begin
        valid_i = 1'b0;
        @(negedge clk);
      end
    end
    drain();
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (bad < 0 && (got_q[i].addr != exp_q[i].addr ||
                      got_q[i].ch != exp_q[i].ch)) bad = i;
    checks++;
    if (got_q.size() != exp_q.size() || bad >= 0) begin
      errors++;
      $display("FAIL rand_stream: got %0d writes (bad idx %0d), required %0d",
               got_q.size(), bad, exp_q.size());
    end
    checks++;
    if (int'(cur_row_o) != m_row || int'(cur_col_o) != m_col) begin
      errors++;
      $display("FAIL rand_cursor: got (%0d,%0d), required (%0d,%0d)",
               cur_row_o, cur_col_o, m_row, m_col);
    end
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_print_ab();
    test_line_wrap();
    test_lf_wrap();
    test_backspace();
    test_form_feed();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
